// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM between a CPU port and a DMA port.
// Accesses are serialised through IDLE -> STROBE -> WAIT -> DONE, and
// simultaneous requests are granted round-robin against the last owner.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  // CPU port
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  // DMA / program-loader port
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_ack,
  output logic [DATA_WIDTH-1:0] dma_rdata,
  // RAM side
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // Status
  output logic                  busy,
  output logic                  owner
);

  // Counter only has to hold RAM_LATENCY-1.
  localparam int               CNT_W    = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic                    owner_q, owner_d;     // 0 = CPU, 1 = DMA
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;
  logic                    grant_dma;

  // Next-state, arbitration and read-data capture.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_dma   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dma_req) begin
          // DMA wins when alone, or on a tie when the CPU owned last.
          grant_dma = dma_req && (!cpu_req || !owner_q);
          owner_d   = grant_dma;
          we_d      = grant_dma ? dma_we    : cpu_we;
          addr_d    = grant_dma ? dma_addr  : cpu_addr;
          wdata_d   = grant_dma ? dma_wdata : cpu_wdata;
          state_d   = S_STROBE;
        end
      end
      S_STROBE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q) dma_rdata_d = mem_rdata;
            else         cpu_rdata_d = mem_rdata;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Outputs decoded from state and latched request.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = (state_q == S_STROBE) && we_q;
  assign mem_re    = ((state_q == S_STROBE) || (state_q == S_WAIT)) && !we_q;
  assign cpu_ack   = (state_q == S_DONE) && !owner_q;
  assign dma_ack   = (state_q == S_DONE) && owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit program/data RAM between two requesters: the CPU memory port and a DMA/program-loader port.
- Sits between the requesters and the RAM. Drives the RAM address, write strobe (RI) and read strobe (RO).
- Serialises accesses with a 4-state FSM and round-robin arbitration, so neither port can starve the other.
- Returns read data and a one-cycle acknowledge to the requester that owned the access.

Parameters:
- ADDR_WIDTH, 8, address width of RAM and both ports.
- DATA_WIDTH, 8, data width of RAM and both ports.
- RAM_LATENCY, 1, cycles from strobe to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; sampled with request.
- cpu_addr  in  ADDR_WIDTH  CPU access address.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  read data; valid from cpu_ack, held until next CPU read completes.
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as cpu_* for the DMA port.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_we  out  1  RAM write strobe (RI).
- mem_re  out  1  RAM read strobe (RO).
- mem_rdata  in  DATA_WIDTH  RAM read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  0 = CPU, 1 = DMA; port of the current or last grant.

Behaviour:
Reset:
- Applied on the clock edge; applies mid-transaction too.
- State -> IDLE; the in-flight access is abandoned with no ack.
- Cleared to 0: mem_addr, mem_wdata, mem_we, mem_re, cpu_ack, dma_ack, cpu_rdata, dma_rdata, busy.
- owner -> 1, so the CPU wins the first tie.

FSM states:
- IDLE:
  - No request: stay in IDLE; strobes low.
  - One request: grant it.
  - Both requests: grant the port opposite to owner (round-robin).
  - On grant: latch addr/we/wdata into internal registers, set owner, go to STROBE.
- STROBE (exactly 1 cycle):
  - mem_addr = latched address.
  - Write: mem_we = 1, mem_wdata = latched data.
  - Read: mem_re = 1.
  - Go to WAIT with the latency counter loaded with RAM_LATENCY-1.
- WAIT (RAM_LATENCY cycles):
  - mem_addr is held.
  - Read: mem_re stays high.
  - Write: mem_we is low, so exactly one write pulse per write access.
  - Counter decrements each cycle.
  - On the cycle the counter is 0: a read captures mem_rdata into the owner's rdata register; go to DONE.
- DONE (1 cycle):
  - Owner's ack = 1; both strobes low.
  - Go to IDLE.

Timing:
- A request sampled in IDLE at edge t gives ack high during cycle t+2+RAM_LATENCY.
- Back-to-back accesses from the same port therefore take RAM_LATENCY+3 cycles each.
- mem_we/mem_re are never both high. At most one ack is high in any cycle.

Handshake rules:
- Requester holds req and its fields stable until ack.
- Req dropped before ack: the access still completes and ack still pulses.
- Req still high in the cycle after ack: treated as a new request and re-arbitrated in IDLE.
- Writes leave the port's rdata unchanged.
- The other port's rdata is never modified.

Boundary conditions:
- Address 0xFF and 0x00 are ordinary addresses; there is no wrap logic, since the address is a passthrough.
- Round-robin guarantee: with both ports requesting continuously, grants strictly alternate.

Test Plan:
- After reset: both ports idle; all outputs 0, busy = 0, owner = 1.
- CPU write 0xA5 to 0x10 with RAM_LATENCY=1:
  - mem_we high exactly 1 cycle with mem_addr=0x10, mem_wdata=0xA5.
  - cpu_ack 3 cycles after request sampled.
  - Then a CPU read of 0x10 returns cpu_rdata=0xA5 with cpu_ack.
- CPU and DMA request in the same cycle, held continuously:
  - Grant order CPU, DMA, CPU, DMA.
  - owner toggles each transaction; acks never overlap.
- RAM_LATENCY=3, DMA read of 0xFF where RAM holds 0x3C:
  - mem_re high 4 cycles.
  - dma_ack 5 cycles after sampling, dma_rdata=0x3C.
  - cpu_rdata is unchanged.
- CPU read in progress, reset pulsed during WAIT:
  - Next cycle state is IDLE, strobes low, no cpu_ack ever.
  - A subsequent request completes normally.
- DMA drops dma_req during STROBE:
  - dma_ack still pulses once; no second access is started.
